// File: rtl/aidan_mcnay_iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the width of the step counter.
package aidan_mcnay_iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The step counter is loaded with nbits itself, so it needs room for that value.
  function automatic int ctr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aidan_mcnay_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module aidan_mcnay_div_step
  import aidan_mcnay_iter_divider_pkg::*;
#(
  parameter int nbits = 16
) (
  input  logic [nbits:0]   p,
  input  logic [nbits-1:0] q,
  input  logic [nbits-1:0] divisor,
  output logic [nbits:0]   p_next,
  output logic [nbits-1:0] q_next
);

  logic [nbits+1:0] p_shift;
  logic [nbits:0]   diff;
  logic             fits;

  // The top bit of p is always zero between steps, because a restored remainder
  // is smaller than the divisor. It is still carried into the compare so that
  // the compare is exact for any input.
  assign p_shift = {p, q[nbits-1]};
  assign fits    = (p_shift >= {2'b00, divisor});
  assign diff    = p_shift[nbits:0] - {1'b0, divisor};

  // Select the restored or reduced remainder and shift the new quotient bit in.
  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    p_next = p_shift[nbits:0];
    if (fits) p_next = diff;
    q_next = {q[nbits-2:0], fits};
  end

endmodule

// File: rtl/aidan_mcnay_iter_divider.sv
// Iterative restoring unsigned divider with val/rdy request and response
// streams. One quotient bit is produced per cycle, and one operation is in
// flight at a time.
module aidan_mcnay_iter_divider
  import aidan_mcnay_iter_divider_pkg::*;
#(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] dividend,
  input  logic [nbits-1:0] divisor,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] quotient,
  output logic [nbits-1:0] remainder
);

  localparam int CW = ctr_width(nbits);

  state_t           state;
  state_t           state_next;
  logic [nbits:0]   p_reg;
  logic [nbits:0]   p_step;
  logic [nbits-1:0] q_reg;
  logic [nbits-1:0] q_step;
  logic [nbits-1:0] d_reg;
  logic [CW-1:0]    cnt;
  logic             req_xfer;
  logic             resp_xfer;

  assign req_xfer  = istream_val & istream_rdy;
  assign resp_xfer = ostream_val & ostream_rdy;

  aidan_mcnay_div_step #(.nbits(nbits)) u_step (
    .p       (p_reg),
    .q       (q_reg),
    .divisor (d_reg),
    .p_next  (p_step),
    .q_next  (q_step)
  );

  // State register. Reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. The counter value 1 marks the last of the nbits steps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_xfer)       state_next = CALC;
      CALC:    if (cnt == CW'(1))  state_next = DONE;
      DONE:    if (resp_xfer)      state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    istream_rdy = (state == IDLE);
    ostream_val = (state == DONE);
  end

  // Operand, partial-remainder and counter registers. They are cleared on reset
  // so the outputs are deterministic even outside DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_reg <= '0;
      q_reg <= '0;
      d_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_xfer) begin
            d_reg <= divisor;
            q_reg <= dividend;
            p_reg <= '0;
            cnt   <= CW'(nbits);
          end
        end
        CALC: begin
          p_reg <= p_step;
          q_reg <= q_step;
          cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are read straight from the registers, which hold steady in DONE.
  assign quotient  = q_reg;
  assign remainder = p_reg[nbits-1:0];

endmodule
